// File: rtl/adc_seq_pkg.sv
// Shared types, constants and the double-dabble step for the ADC sample sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, START, WAIT_DATA, ACCUM, CONVERT, PUBLISH
  } seq_state_t;

  localparam int BCD_DIGITS         = 4;
  localparam int CONV_CYCLES        = 12;
  localparam int BIN_W              = 12;
  localparam int BCD_W              = 4 * BCD_DIGITS;
  localparam int DEF_PERIOD_CYCLES  = 100000;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_AVG_LOG2       = 2;

  // One double-dabble iteration: add-3 correction on every nibble >= 5, then shift left.
  function automatic logic [BCD_W+BIN_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                     input logic [BIN_W-1:0] bin);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj, bin} << 1;
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_bin2bcd.sv
// Iterative 12-bit binary to 4-digit BCD converter, one bit per clock.
module bin2bcd_seq
  import adc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] shreg;
  logic [3:0]       cnt;
  logic             busy;

  // The start edge already performs the first iteration, so done lands on the 12th edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd   <= '0;
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {bcd, shreg} <= dd_step('0, bin);
        cnt          <= 4'd1;
        busy         <= 1'b1;
      end else if (busy) begin
        {bcd, shreg} <= dd_step(bcd, shreg);
        cnt          <= cnt + 4'd1;
        if (cnt == 4'(CONV_CYCLES - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Periodic SPI ADC request scheduler: averages 2^AVG_LOG2 samples and publishes BCD digits.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int AVG_LOG2       = DEF_AVG_LOG2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int DATA_W         = BIN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              spi_start,
  input  logic [DATA_W-1:0] spi_data,
  input  logic              spi_data_valid,
  output logic [DATA_W-1:0] avg_value,
  output logic [3:0]        ones,
  output logic [3:0]        tens,
  output logic [3:0]        hundreds,
  output logic [3:0]        thousands,
  output logic              bcd_valid,
  output logic              timeout_err,
  output logic              overrun_err
);

  localparam int PW    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CW    = AVG_LOG2 + 1;

  localparam logic [PW-1:0] P_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] N_AVG   = CW'(1 << AVG_LOG2);

  seq_state_t        state;
  logic [PW-1:0]     pcnt;
  logic              tick;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tcnt_next;
  logic [DATA_W-1:0] sample;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [CW-1:0]     scnt;
  logic [CW-1:0]     scnt_next;
  logic              last_sample;
  logic              conv_start;
  logic [DATA_W-1:0] conv_bin;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           pcnt <= '0;
    else if (!enable || pcnt == P_LAST)  pcnt <= '0;
    else                                 pcnt <= pcnt + PW'(1);
  end

  assign tick        = enable && (pcnt == P_LAST);
  assign tcnt_next   = tcnt + TW'(1);
  assign acc_sum     = acc + ACC_W'(sample);
  assign scnt_next   = scnt + CW'(1);
  assign last_sample = (scnt_next == N_AVG);
  assign conv_bin    = acc_sum[AVG_LOG2 +: DATA_W];
  assign conv_start  = enable && (state == ACCUM) && last_sample;

  bin2bcd_seq u_b2b (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      sample      <= '0;
      acc         <= '0;
      scnt        <= '0;
      spi_start   <= 1'b0;
      avg_value   <= '0;
      ones        <= '0;
      tens        <= '0;
      hundreds    <= '0;
      thousands   <= '0;
      bcd_valid   <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      bcd_valid <= 1'b0;
      // Ticks are never queued: one landing mid-transaction is simply lost.
      if (tick && state != WAIT_TICK && state != IDLE) overrun_err <= 1'b1;
      if (!enable) begin
        state <= IDLE;
        acc   <= '0;
        scnt  <= '0;
      end else begin
        case (state)
          IDLE: state <= WAIT_TICK;
          WAIT_TICK: if (tick) begin
            state     <= START;
            spi_start <= 1'b1;
          end
          START: begin
            tcnt  <= '0;
            state <= WAIT_DATA;
          end
          WAIT_DATA: begin
            tcnt <= tcnt_next;
            if (spi_data_valid) begin
              sample <= spi_data;
              state  <= ACCUM;
            end else if (tcnt_next == T_LIMIT) begin
              timeout_err <= 1'b1;
              state       <= WAIT_TICK;
            end
          end
          ACCUM: begin
            if (last_sample) begin
              avg_value <= conv_bin;
              acc       <= '0;
              scnt      <= '0;
              state     <= CONVERT;
            end else begin
              acc   <= acc_sum;
              scnt  <= scnt_next;
              state <= WAIT_TICK;
            end
          end
          CONVERT: if (conv_done) begin
            {thousands, hundreds, tens, ones} <= conv_bcd;
            bcd_valid <= 1'b1;
            state     <= PUBLISH;
          end
          PUBLISH: state <= WAIT_TICK;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
